// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 incrementing-burst master: command in, linear burst out, read beats / write data streamed.
// Latency: wb_cyc_o one cycle after command accept; rd_valid_o one cycle after each ack; done_o one cycle after last ack/abort.
// Backpressure: cmd_ready_o only in IDLE; write data throttled via wr_ready_o (stb drops when buffer empty); reads have none.
//
// Ports: wb_clk_i/wb_rst_i (async active-low) clock/reset; cmd_* command handshake (we, start address, 1..16 beats);
//        wr_* write data stream; rd_valid_o/rd_data_o read beats; done_o/err_o completion status; wb_* Wishbone B3 master bus.
// Optional feature: define WB_B3_MASTER_TIMEOUT_EN to abort a beat that waits timeout_cycles without an ack.
module wb_b3_burst_master #(
    parameter int aw             = 32,
    parameter int dw             = 32,
    parameter int timeout_cycles = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [4:0]    cmd_len_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [dw-1:0] wr_data_i,
    output logic          rd_valid_o,
    output logic [dw-1:0] rd_data_o,
    output logic          done_o,
    output logic          err_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

    state_t     state;
    logic       single_q;    // len==1 burst uses classic cycle encoding
    logic       buf_full;    // write beat held in wb_dat_o awaiting ack
    logic [4:0] beats_left;  // beats still to be acked
    logic [4:0] load_left;   // write beats not yet pulled from wr_* stream
    logic [4:0] len_eff;
    logic       beat_ack;
    logic       bus_fault;
    logic       timeout_hit;
    logic       load_beat;

    function automatic logic [2:0] cti_for(input logic single, input logic [4:0] rem);
        if (single)
            return 3'b000;
        else if (rem == 5'd1)
            return 3'b111;
        else
            return 3'b010;
    endfunction

    assign len_eff     = (cmd_len_i == 5'd0) ? 5'd1 : cmd_len_i;
    // Slave responses only count while a beat is actually being strobed.
    assign beat_ack    = wb_stb_o & wb_ack_i & ~wb_err_i & ~wb_rty_i;
    assign bus_fault   = wb_stb_o & (wb_err_i | wb_rty_i);
    assign cmd_ready_o = (state == IDLE);
    // The buffer may be refilled in the same cycle its current beat is acked.
    assign wr_ready_o  = (state == ACTIVE) & wb_we_o & (~buf_full | beat_ack) & (load_left != 5'd0);
    assign load_beat   = wr_ready_o & wr_valid_i;
    assign wb_sel_o    = 4'hf;
    assign wb_bte_o    = 2'b00;

`ifdef WB_B3_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);
    logic [7:0] to_cnt;

    // Held at zero while stb is low, so each stb rise starts a fresh wait.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            to_cnt <= 8'd0;
        else if (!wb_stb_o || wb_ack_i)
            to_cnt <= 8'd0;
        else
            to_cnt <= to_cnt + 8'd1;
    end

    assign timeout_hit = wb_stb_o & ~wb_ack_i & ~wb_err_i & ~wb_rty_i & (to_cnt == TO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state      <= IDLE;
            single_q   <= 1'b0;
            buf_full   <= 1'b0;
            beats_left <= 5'd0;
            load_left  <= 5'd0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cti_o   <= 3'b000;
        end else begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state      <= ACTIVE;
                        single_q   <= (len_eff == 5'd1);
                        beats_left <= len_eff;
                        load_left  <= cmd_we_i ? len_eff : 5'd0;
                        buf_full   <= 1'b0;
                        wb_adr_o   <= cmd_adr_i;
                        wb_we_o    <= cmd_we_i;
                        wb_cti_o   <= cti_for(len_eff == 5'd1, len_eff);
                        wb_cyc_o   <= 1'b1;
                        // Reads strobe at once; writes wait for the first data word.
                        wb_stb_o   <= ~cmd_we_i;
                    end
                end
                ACTIVE: begin
                    if (bus_fault || timeout_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_cti_o <= 3'b000;
                        buf_full <= 1'b0;
                        done_o   <= 1'b1;
                        err_o    <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        if (beat_ack) begin
                            wb_adr_o   <= wb_adr_o + aw'(4);
                            beats_left <= beats_left - 5'd1;
                            wb_cti_o   <= cti_for(single_q, beats_left - 5'd1);
                            if (!wb_we_o) begin
                                rd_valid_o <= 1'b1;
                                rd_data_o  <= wb_dat_i;
                            end
                            if (beats_left == 5'd1) begin
                                wb_cyc_o <= 1'b0;
                                wb_stb_o <= 1'b0;
                                wb_we_o  <= 1'b0;
                                wb_cti_o <= 3'b000;
                                buf_full <= 1'b0;
                                done_o   <= 1'b1;
                                state    <= FINISH;
                            end else if (wb_we_o && !load_beat) begin
                                // No next word ready: insert a master wait state.
                                buf_full <= 1'b0;
                                wb_stb_o <= 1'b0;
                            end
                        end
                        if (load_beat) begin
                            wb_dat_o  <= wr_data_i;
                            buf_full  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            load_left <= load_left - 5'd1;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
module tb_wb_b3_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [4:0]  cmd_len_i = '0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [31:0] wr_data_i = '0;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        done_o, err_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    int nvec = 0;
    int nerr = 0;

    wb_b3_burst_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk = ~clk;

    // Slave memory, word indexed by adr[9:2]; preloaded with 32'hC0DE_0000 | index.
    logic [31:0] mem [0:255];

    // Slave behaviour knobs and observation log.
    int slv_wait = 0;
    int slv_err_beat = 0;
    bit slv_mute = 1'b0;
    int wait_cnt, beat_n, cyc_n, stb_hi, cyc_nostb, cti_nonzero;
    int done_cnt, done_cyc, fault_cyc;
    logic done_err, done_with_cyc;
    logic [31:0] adr_q[$];
    logic [2:0]  cti_q[$];
    int          ack_cyc_q[$];
    logic [31:0] rd_q[$];
    int          rd_cyc_q[$];

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
            stb_hi = stb_hi + 1;
            if (wb_cti_o != 3'b000) cti_nonzero = cti_nonzero + 1;
            if (!slv_mute) begin
                if (wait_cnt < slv_wait) begin
                    wait_cnt = wait_cnt + 1;
                end else begin
                    wait_cnt = 0;
                    beat_n = beat_n + 1;
                    if (beat_n == slv_err_beat) begin
                        wb_err_i = 1'b1;
                        fault_cyc = cyc_n;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) mem[wb_adr_o[9:2]] = wb_dat_o;
                        else wb_dat_i = mem[wb_adr_o[9:2]];
                        adr_q.push_back(wb_adr_o);
                        cti_q.push_back(wb_cti_o);
                        ack_cyc_q.push_back(cyc_n);
                    end
                end
            end
        end
        if (wb_cyc_o && !wb_stb_o) cyc_nostb = cyc_nostb + 1;
        if (rd_valid_o) begin
            rd_q.push_back(rd_data_o);
            rd_cyc_q.push_back(cyc_n);
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_err = err_o;
            done_cyc = cyc_n;
            done_with_cyc = wb_cyc_o;
        end
    end

    task automatic clear_log();
        adr_q.delete(); cti_q.delete(); ack_cyc_q.delete(); rd_q.delete(); rd_cyc_q.delete();
        wait_cnt = 0; beat_n = 0; stb_hi = 0; cyc_nostb = 0; cti_nonzero = 0;
        done_cnt = 0; done_cyc = 0; fault_cyc = 0; done_err = 1'b0; done_with_cyc = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [4:0] len);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt == 0) begin
            nvec++; nerr++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", tag, budget);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if ({wb_cyc_o, wb_stb_o, wb_we_o, rd_valid_o, done_o, err_o, wr_ready_o} !== 7'b0) begin
            nerr++; $display("FAIL rst_ctl: got %b want 0000000", {wb_cyc_o, wb_stb_o, wb_we_o, rd_valid_o, done_o, err_o, wr_ready_o}); end
        nvec++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
            nerr++; $display("FAIL rst_adr_dat: got %h/%h want 0/0", wb_adr_o, wb_dat_o); end
        nvec++; if (wb_cti_o !== 3'b000 || wb_sel_o !== 4'hf || wb_bte_o !== 2'b00) begin
            nerr++; $display("FAIL rst_cti_sel_bte: got %b/%h/%b want 000/f/00", wb_cti_o, wb_sel_o, wb_bte_o); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        nvec++; if (cmd_ready_o !== 1'b1) begin nerr++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready_o); end
    endtask

    task automatic test_read_single();
        clear_log(); slv_wait = 2;
        issue(1'b0, 32'h100, 5'd1);
        nvec++; if (wb_cyc_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            nerr++; $display("FAIL rd1_cyc: got cyc=%b rdy=%b want 1/0", wb_cyc_o, cmd_ready_o); end
        wait_done(50, "rd1");
        nvec++; if (stb_hi !== 3) begin nerr++; $display("FAIL rd1_wait: got %0d stb cycles want 3", stb_hi); end
        nvec++; if (cti_nonzero !== 0) begin nerr++; $display("FAIL rd1_cti: got %0d non-classic cycles want 0", cti_nonzero); end
        nvec++; if (rd_q.size() !== 1 || rd_q[0] !== 32'hC0DE_0040) begin
            nerr++; $display("FAIL rd1_data: got n=%0d d=%h want 1/c0de0040", rd_q.size(), rd_q[0]); end
        nvec++; if (done_cnt !== 1 || done_err !== 1'b0) begin
            nerr++; $display("FAIL rd1_done: got cnt=%0d err=%b want 1/0", done_cnt, done_err); end
        slv_wait = 0;
    endtask

    task automatic test_read_burst();
        logic [2:0] exp_cti [4];
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010; exp_cti[2] = 3'b010; exp_cti[3] = 3'b111;
        clear_log();
        issue(1'b0, 32'h200, 5'd4);
        wait_done(50, "rd4");
        nvec++; if (adr_q.size() !== 4 || rd_q.size() !== 4) begin
            nerr++; $display("FAIL rd4_count: got beats=%0d rd=%0d want 4/4", adr_q.size(), rd_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                nvec++; if (adr_q[i] !== 32'h200 + 32'(4 * i) || cti_q[i] !== exp_cti[i] || ack_cyc_q[i] !== ack_cyc_q[0] + i) begin
                    nerr++; $display("FAIL rd4_beat%0d: got adr=%h cti=%b cyc+%0d want %h/%b/+%0d", i, adr_q[i], cti_q[i],
                                     ack_cyc_q[i] - ack_cyc_q[0], 32'h200 + 32'(4 * i), exp_cti[i], i); end
                nvec++; if (rd_q[i] !== (32'hC0DE_0080 | 32'(i)) || rd_cyc_q[i] !== ack_cyc_q[i] + 1) begin
                    nerr++; $display("FAIL rd4_rd%0d: got %h at ack+%0d want %h at ack+1", i, rd_q[i],
                                     rd_cyc_q[i] - ack_cyc_q[i], 32'hC0DE_0080 | 32'(i)); end
            end
        end
        nvec++; if (done_cnt !== 1 || done_err !== 1'b0) begin
            nerr++; $display("FAIL rd4_done: got cnt=%0d err=%b want 1/0", done_cnt, done_err); end
    endtask

    task automatic test_write_gap();
        logic [31:0] wdat [3];
        int idx = 0;
        int gap = 0;
        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC;
        clear_log();
        issue(1'b1, 32'h40, 5'd3);
        for (int n = 0; n < 60 && done_cnt == 0; n++) begin
            wr_valid_i = (idx < 3) && !(idx == 1 && gap < 2);
            wr_data_i  = wdat[idx % 3];
            @(negedge clk); #1;
            if (wr_valid_i && wr_ready_o) idx++;
            else if (idx == 1 && gap < 2) gap++;
            if (done_cnt == 0) begin @(posedge clk); #1; end
        end
        wr_valid_i = 1'b0;
        wait_done(20, "wr3");
        nvec++; if (mem[16] !== 32'hA || mem[17] !== 32'hB || mem[18] !== 32'hC) begin
            nerr++; $display("FAIL wr3_mem: got %h %h %h want a b c", mem[16], mem[17], mem[18]); end
        nvec++; if (cyc_nostb !== 3) begin nerr++; $display("FAIL wr3_waitstates: got %0d cyc-only cycles want 3", cyc_nostb); end
        nvec++; if (idx !== 3) begin nerr++; $display("FAIL wr3_consumed: got %0d words want 3", idx); end
        nvec++; if (done_cnt !== 1 || done_err !== 1'b0) begin
            nerr++; $display("FAIL wr3_done: got cnt=%0d err=%b want 1/0", done_cnt, done_err); end
    endtask

    task automatic test_error_abort();
        clear_log(); slv_err_beat = 3;
        issue(1'b0, 32'h300, 5'd8);
        wait_done(50, "err");
        repeat (3) @(negedge clk);
        #1;
        nvec++; if (rd_q.size() !== 2 || rd_q[0] !== 32'hC0DE_00C0 || rd_q[1] !== 32'hC0DE_00C1) begin
            nerr++; $display("FAIL err_rd: got n=%0d want 2 beats c0de00c0,c0de00c1", rd_q.size()); end
        nvec++; if (done_cyc !== fault_cyc + 1 || done_with_cyc !== 1'b0) begin
            nerr++; $display("FAIL err_drop: got done at fault+%0d cyc=%b want +1/0", done_cyc - fault_cyc, done_with_cyc); end
        nvec++; if (done_cnt !== 1 || done_err !== 1'b1) begin
            nerr++; $display("FAIL err_done: got cnt=%0d err=%b want 1/1", done_cnt, done_err); end
        slv_err_beat = 0;
    endtask

    task automatic test_timeout();
        clear_log(); slv_mute = 1'b1;
        issue(1'b0, 32'h80, 5'd1);
`ifdef WB_B3_MASTER_TIMEOUT_EN
        wait_done(400, "tmo");
        nvec++; if (stb_hi !== 255) begin nerr++; $display("FAIL tmo_len: got %0d wait cycles want 255", stb_hi); end
        nvec++; if (done_cnt !== 1 || done_err !== 1'b1) begin
            nerr++; $display("FAIL tmo_done: got cnt=%0d err=%b want 1/1", done_cnt, done_err); end
`else
        repeat (300) @(negedge clk);
        #1;
        nvec++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
            nerr++; $display("FAIL tmo_hold: got cyc=%b stb=%b want 1/1", wb_cyc_o, wb_stb_o); end
        nvec++; if (done_cnt !== 0) begin nerr++; $display("FAIL tmo_nodone: got %0d done want 0", done_cnt); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
`endif
        slv_mute = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        clear_log();
        issue(1'b0, 32'h000, 5'd16);
        while (adr_q.size() < 1 && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #2;
        nvec++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h4) begin
            nerr++; $display("FAIL mrst_beat2: got stb=%b adr=%h want 1/00000004", wb_stb_o, wb_adr_o); end
        rst_n = 1'b0;
        #1;
        nvec++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            nerr++; $display("FAIL mrst_async: got cyc=%b stb=%b want 0/0", wb_cyc_o, wb_stb_o); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++; if (done_cnt !== 0 || cmd_ready_o !== 1'b1) begin
            nerr++; $display("FAIL mrst_nodone: got done=%0d rdy=%b want 0/1", done_cnt, cmd_ready_o); end
        clear_log();
        issue(1'b0, 32'h20, 5'd2);
        wait_done(50, "mrst_next");
        nvec++; if (rd_q.size() !== 2 || rd_q[1] !== 32'hC0DE_0009 || done_err !== 1'b0) begin
            nerr++; $display("FAIL mrst_next: got n=%0d d1=%h err=%b want 2/c0de0009/0", rd_q.size(), rd_q[1], done_err); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        issue(1'b0, 32'h10, 5'd0);
        wait_done(50, "b2b0");
        nvec++; if (rd_q.size() !== 1 || rd_q[0] !== 32'hC0DE_0004 || cti_q[0] !== 3'b000) begin
            nerr++; $display("FAIL b2b_len0: got n=%0d d=%h cti=%b want 1/c0de0004/000", rd_q.size(), rd_q[0], cti_q[0]); end
        clear_log();
        issue(1'b0, 32'hFFFF_FFFC, 5'd2);
        wait_done(50, "wrap");
        nvec++; if (adr_q.size() !== 2 || adr_q[0] !== 32'hFFFF_FFFC || adr_q[1] !== 32'h0) begin
            nerr++; $display("FAIL wrap_adr: got n=%0d a1=%h want 2/00000000", adr_q.size(), adr_q[1]); end
        nvec++; if (rd_q.size() !== 2 || rd_q[0] !== 32'hC0DE_00FF || rd_q[1] !== 32'hC0DE_0000) begin
            nerr++; $display("FAIL wrap_data: got n=%0d want c0de00ff,c0de0000", rd_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        cyc_n = 0;
        clear_log();
        test_reset();
        test_read_single();
        test_read_burst();
        test_write_gap();
        test_error_abort();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
